// File: rtl/screen_sequencer_if.sv
// Handshake bundle between the game/start logic and the screen sequencer.
// The sequencer takes the slave side; whatever drives start/game-over takes the master side.
interface screen_sequencer_if;
    logic       iStart;
    logic       iTwoPlayer;
    logic       iGameOver;
    logic       iWinner;
    logic       oDraw;
    logic [2:0] oSelect;
    logic       oGameEnable;
    logic       oBusy;
    logic       oFrameDone;

    modport master (
        output iStart,
        output iTwoPlayer,
        output iGameOver,
        output iWinner,
        input  oDraw,
        input  oSelect,
        input  oGameEnable,
        input  oBusy,
        input  oFrameDone
    );

    modport slave (
        input  iStart,
        input  iTwoPlayer,
        input  iGameOver,
        input  iWinner,
        output oDraw,
        output oSelect,
        output oGameEnable,
        output oBusy,
        output oFrameDone
    );
endinterface

// File: rtl/screen_sequencer.sv
// Chooses which full-screen image the ROM drawer paints, holds draw-enable for one
// whole raster per image, and gates the game between title, mode and winner screens.
module screen_sequencer #(
    parameter int FRAME_PIXELS = 76800,
    parameter int HOLD_CYCLES  = 100000000
) (
    input  logic                  iClock,
    input  logic                  iReset,
    screen_sequencer_if.slave     bus
);
    localparam int DRAW_W = ($clog2(FRAME_PIXELS) > 17) ? $clog2(FRAME_PIXELS) : 17;
    localparam int HOLD_W = ($clog2(HOLD_CYCLES) > 27) ? $clog2(HOLD_CYCLES) : 27;
    localparam logic [DRAW_W-1:0] DRAW_LAST = DRAW_W'(FRAME_PIXELS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [2:0] SCR_TITLE = 3'd0;
    localparam logic [2:0] SCR_RED   = 3'd1;
    localparam logic [2:0] SCR_BLUE  = 3'd2;
    localparam logic [2:0] SCR_ONE   = 3'd3;
    localparam logic [2:0] SCR_TWO   = 3'd4;

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_DRAW       = 3'd1,
        S_WAIT_START = 3'd2,
        S_HOLD       = 3'd3,
        S_GAME       = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_screen;
    logic [2:0]        w_screen_next;
    logic [DRAW_W-1:0] r_draw_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_frame_done;
    logic              w_draw_last;
    logic              w_hold_last;

    assign w_draw_last = (r_draw_cnt == DRAW_LAST);
    assign w_hold_last = (r_hold_cnt == HOLD_LAST);

    // State register
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; the screen id only moves on an edge that enters S_DRAW
    always_comb begin
        w_state_next  = r_state;
        w_screen_next = r_screen;
        case (r_state)
            S_INIT: begin
                w_state_next  = S_DRAW;
                w_screen_next = SCR_TITLE;
            end
            S_DRAW: begin
                if (w_draw_last) begin
                    w_state_next = (r_screen == SCR_TITLE) ? S_WAIT_START : S_HOLD;
                end
            end
            S_WAIT_START: begin
                if (bus.iStart) begin
                    w_state_next  = S_DRAW;
                    w_screen_next = bus.iTwoPlayer ? SCR_TWO : SCR_ONE;
                end
            end
            S_HOLD: begin
                if (w_hold_last) begin
                    if (r_screen == SCR_RED || r_screen == SCR_BLUE) begin
                        w_state_next  = S_DRAW;
                        w_screen_next = SCR_TITLE;
                    end else begin
                        w_state_next = S_GAME;
                    end
                end
            end
            S_GAME: begin
                if (bus.iGameOver) begin
                    w_state_next  = S_DRAW;
                    w_screen_next = bus.iWinner ? SCR_BLUE : SCR_RED;
                end
            end
            default: begin
                w_state_next  = S_INIT;
                w_screen_next = SCR_TITLE;
            end
        endcase
    end

    // Counters run only while in their state and self-clear on the terminal count
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_screen     <= SCR_TITLE;
            r_draw_cnt   <= '0;
            r_hold_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_screen     <= w_screen_next;
            r_frame_done <= (r_state == S_DRAW) && w_draw_last;
            if (r_state == S_DRAW && !w_draw_last) begin
                r_draw_cnt <= r_draw_cnt + 1'b1;
            end else begin
                r_draw_cnt <= '0;
            end
            if (r_state == S_HOLD && !w_hold_last) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        bus.oDraw       = (r_state == S_DRAW);
        bus.oGameEnable = (r_state == S_GAME);
        bus.oBusy       = (r_state == S_DRAW) || (r_state == S_HOLD);
        bus.oSelect     = r_screen;
        bus.oFrameDone  = r_frame_done;
    end
endmodule

// File: tb/tb_screen_sequencer.sv
// Randomised bench: a driver walks the title/game/winner flow and queues the expected
// screen sequence; a monitor checks each drawn frame and the hold gaps against it.
module tb_screen_sequencer;
    localparam int FP = 16;
    localparam int HC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    screen_sequencer_if bus();

    screen_sequencer #(.FRAME_PIXELS(FP), .HOLD_CYCLES(HC)) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int pushed = 0;
    int falls  = 0;
    bit expect_abort = 1'b0;
    int abort_len = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_screen(input int s);
        exp_q.push_back(s);
        pushed++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(falls == pushed && !bus.oBusy && !bus.oGameEnable && !bus.oDraw) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!(falls == pushed && !bus.oBusy && !bus.oGameEnable && !bus.oDraw)) begin
            total++;
            bad++;
            $display("FAIL wait_idle: timed out after %0d cycles, falls=%0d need %0d", n, falls, pushed);
        end
    endtask

    task automatic wait_game();
        int n = 0;
        while (!bus.oGameEnable && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.oGameEnable) begin
            total++;
            bad++;
            $display("FAIL wait_game: oGameEnable still 0 after %0d cycles", n);
        end
    endtask

    // Monitor: one line per frame, checks select, length, frame-done and hold gaps
    initial begin
        int run = 0;
        int sel0 = 0;
        int last_sel = 0;
        int last_fall = -1000;
        int e;
        bit prev_d = 1'b0;
        bit prev_ge = 1'b0;
        bit sel_moved = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.oDraw && !prev_d) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got select %0d want no frame", bus.oSelect);
                end else begin
                    e = exp_q.pop_front();
                    chk("select_at_rise", int'(bus.oSelect), e);
                end
                if (last_sel == 1 || last_sel == 2) chk("winner_hold_gap", cyc - last_fall, HC);
                sel0 = int'(bus.oSelect);
                run = 0;
                sel_moved = 1'b0;
            end
            if (bus.oDraw) begin
                run++;
                if (int'(bus.oSelect) != sel0) sel_moved = 1'b1;
            end
            if (!bus.oDraw && prev_d) begin
                falls++;
                $display("frame: select=%0d length=%0d frame_done=%0d busy=%0d", sel0, run, bus.oFrameDone, bus.oBusy);
                chk("select_stable", int'(sel_moved), 0);
                if (expect_abort) begin
                    chk("abort_len", run, abort_len);
                    chk("abort_frame_done", int'(bus.oFrameDone), 0);
                    expect_abort = 1'b0;
                    last_sel = 0;
                end else begin
                    chk("draw_len", run, FP);
                    chk("frame_done_pulse", int'(bus.oFrameDone), 1);
                    chk("busy_after_draw", int'(bus.oBusy), int'(sel0 != 0));
                    last_sel = sel0;
                end
                last_fall = cyc;
            end else if (bus.oFrameDone) begin
                total++;
                bad++;
                $display("FAIL stray_frame_done: got 1 want 0 (cycle %0d)", cyc);
            end
            if (bus.oGameEnable && !prev_ge) begin
                chk("game_hold_gap", cyc - last_fall, HC);
                chk("game_after_mode_screen", int'(last_sel == 3 || last_sel == 4), 1);
                chk("busy_in_game", int'(bus.oBusy), 0);
            end
            prev_d  = bus.oDraw;
            prev_ge = bus.oGameEnable;
        end
    end

    // Driver
    initial begin
        bit two;
        bit win;
        bus.iStart     = 1'b0;
        bus.iTwoPlayer = 1'b0;
        bus.iGameOver  = 1'b0;
        bus.iWinner    = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_draw", int'(bus.oDraw), 0);
        chk("reset_select", int'(bus.oSelect), 0);
        chk("reset_game_enable", int'(bus.oGameEnable), 0);
        chk("reset_busy", int'(bus.oBusy), 0);
        chk("reset_frame_done", int'(bus.oFrameDone), 0);
        push_screen(0);
        rst = 1'b0;

        for (int round = 0; round < 8; round++) begin
            wait_idle();
            // game-over is meaningless while waiting for start
            bus.iGameOver = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            chk("wait_ignores_gameover_draw", int'(bus.oDraw), 0);
            chk("wait_ignores_gameover_game", int'(bus.oGameEnable), 0);
            chk("wait_select_title", int'(bus.oSelect), 0);

            two = (round == 0) ? 1'b0 : (round == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.iGameOver  = (round == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.iTwoPlayer = two;
            bus.iStart     = 1'b1;
            push_screen(two ? 4 : 3);
            @(negedge clk);
            bus.iStart    = 1'b0;
            bus.iGameOver = 1'b0;
            chk("mode_draw_started", int'(bus.oDraw), 1);

            repeat (3) @(negedge clk);
            bus.iStart     = 1'b1;
            bus.iTwoPlayer = ~two;
            repeat (4) @(negedge clk);
            bus.iStart = 1'b0;

            wait_game();
            bus.iStart = 1'b1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            chk("game_ignores_start", int'(bus.oGameEnable), 1);
            bus.iStart = 1'b0;

            win = 1'($urandom_range(0, 1));
            bus.iWinner   = win;
            bus.iGameOver = 1'b1;
            push_screen(win ? 2 : 1);
            push_screen(0);
            @(negedge clk);
            bus.iGameOver = 1'b0;
            chk("game_ends", int'(bus.oGameEnable), 0);
            chk("winner_draw_started", int'(bus.oDraw), 1);

            if (round == 2) begin
                repeat (6) @(negedge clk);
                abort_len = 7;
                expect_abort = 1'b1;
                rst = 1'b1;
                @(negedge clk);
                chk("midreset_draw", int'(bus.oDraw), 0);
                chk("midreset_select", int'(bus.oSelect), 0);
                chk("midreset_game_enable", int'(bus.oGameEnable), 0);
                rst = 1'b0;
            end
        end

        wait_idle();
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
